uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Controller that sequences the 16x-oversampling UART receiver. It generates the receiver's bd_tick from a programmable divisor and captures every received byte on rx_done into a first-word-fall-through FIFO. It exposes FIFO status, sticky overrun and a level interrupt to the bus-side register logic, and sits between the receiver and the Wishbone slave register block.

Parameters:
FIFO_DEPTH, 8, receive FIFO entries; power of two, 2..64
DIV_WIDTH, 16, width of baud divisor
IRQ_LEVEL, 4, fill level at or above which rx_irq asserts; 1..FIFO_DEPTH

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  baud tick generation enable
divisor  in  DIV_WIDTH  tick period minus one, in clk cycles
bd_tick  out  1  one-cycle oversampling tick to receiver
rx_done  in  1  one-cycle pulse from receiver: byte complete
r_data  in  8  received byte, valid when rx_done=1
rd_en  in  1  pop request from bus side
rd_data  out  8  FIFO head byte (FWFT)
rd_valid  out  1  FIFO not empty
fifo_full  out  1  FIFO holds FIFO_DEPTH bytes
level  out  clog2(FIFO_DEPTH)+1  current fill count
overrun  out  1  sticky: byte dropped while full
clr_overrun  in  1  clears overrun
rx_irq  out  1  level >= IRQ_LEVEL

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (reset_n).
- Reset (async, any time, including mid-byte):
  - baud counter=0, bd_tick=0.
  - FIFO pointers=0, level=0, rd_valid=0, fifo_full=0, overrun=0, rx_irq=0, rd_data=0.
  - FIFO storage is not reset.
- Baud generator:
  - While enable=0, the counter is held at 0 and bd_tick=0.
  - While enable=1, if cnt >= divisor then bd_tick=1 (registered output, same cycle as the comparison) and cnt<=0; else cnt<=cnt+1.
  - divisor=0 gives a tick every cycle. The tick period is divisor+1 cycles.
  - A divisor change takes effect immediately. The >= compare guarantees no long wrap when the divisor is reduced below the current count.
- FIFO push:
  - rx_done=1 and (not full or pop this cycle) -> write r_data at wr_ptr, wr_ptr+1 mod FIFO_DEPTH.
  - rx_done=1 while full with no pop -> byte dropped, overrun<=1, FIFO unchanged.
- FIFO pop:
  - rd_en=1 and rd_valid=1 -> rd_ptr+1 mod FIFO_DEPTH.
  - rd_en while empty is ignored; no pointer or level change, no error.
- Simultaneous push and pop:
  - Non-empty: both occur, level unchanged.
  - Full: both occur, no overrun.
  - Empty: push only; the pop is ignored.
- Level and status:
  - level is registered: +1 push only, -1 pop only, unchanged otherwise. It never exceeds FIFO_DEPTH or goes below 0.
  - rd_valid = level!=0.
  - fifo_full = level==FIFO_DEPTH.
  - rx_irq = level>=IRQ_LEVEL, all combinational from the registered level.
- rd_data:
  - When rd_valid=1, equals mem[rd_ptr] combinationally. A byte pushed in cycle N is visible on rd_data in cycle N+1.
  - When rd_valid=0, rd_data=0.
- Overrun:
  - Sticky. clr_overrun=1 clears it next cycle.
  - A simultaneous set and clear leaves overrun=1 (set wins).
- Pointers: width clog2(FIFO_DEPTH), natural wrap. Full/empty are decided by level, not by pointer compare.
- Latency: rx_done to rd_valid is 1 cycle. rd_en to next head on rd_data is 1 cycle.

Decomposition:
- Shared package uart_pkg:
  - UART_OVERSAMPLE=16.
  - Default divisor constant for 100 MHz/115200 (DIV_115200=53).
  - Byte width constant DATA_W=8.
- One sub-module: uart_baud_gen (enable, divisor -> bd_tick).
- The FIFO stays inline in uart_rx_ctrl.

Test Plan:
- Reset then enable=1, divisor=3 -> bd_tick pulses every 4th cycle; enable=0 -> no ticks, counter restarts at 0 on re-enable.
- divisor=10, wait until cnt=8, set divisor=2 -> tick the next cycle, then every 3 cycles.
- Push 0xA5, 0x3C, 0x7E via rx_done pulses -> rd_valid one cycle after first push. Three pops with rd_en return A5, 3C, 7E, then rd_valid=0, rd_data=0.
- Push 9 bytes (0x01..0x09) with FIFO_DEPTH=8 -> fifo_full after 8th, overrun=1 after 9th. Drain returns 01..08. clr_overrun asserted together with a new overflow keeps overrun=1.
- Full FIFO, rx_done and rd_en in same cycle with r_data=0x55 -> level stays 8, overrun=0, 0x55 read last. Empty FIFO, rd_en alone -> no change.
- Fill to 4 bytes -> rx_irq=1 at level 4; assert reset_n=0 mid-stream -> all outputs 0 immediately (async), level=0 after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: oversampling ratio, default baud divisor and byte width.
package uart_pkg;
  localparam int UART_OVERSAMPLE = 16;
  // 100 MHz / (115200 * 16) - 1, rounded.
  localparam int DIV_115200 = 53;
  localparam int DATA_W = 8;
endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: one-cycle bd_tick every divisor+1 clocks while enabled.
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 bd_tick
);
  logic [DIV_WIDTH-1:0] cnt_d, cnt_q;
  logic                 tick_d, tick_q;

  // The >= compare makes a divisor reduced below the running count fire at once
  // instead of wrapping through the whole counter range.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (enable) begin
      if (cnt_q >= divisor) begin
        tick_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign bd_tick = tick_q;
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick generation plus a first-word-fall-through
// receive FIFO with fill level, sticky overrun and level interrupt.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int IRQ_LEVEL  = 4,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 bd_tick,
  input  logic                 rx_done,
  input  logic [DATA_W-1:0]    r_data,
  input  logic                 rd_en,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  output logic                 fifo_full,
  output logic [LVL_W-1:0]     level,
  output logic                 overrun,
  input  logic                 clr_overrun,
  output logic                 rx_irq
);
  uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .divisor (divisor),
    .bd_tick (bd_tick)
  );

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_d, rd_ptr_q;
  logic [LVL_W-1:0]  level_d, level_q;
  logic              overrun_d, overrun_q;
  logic              push, pop;

  // Handshake: rx_done is a one-cycle strobe with r_data valid in that cycle and
  // no backpressure (a byte arriving while full is dropped and flagged). On the
  // read side rd_valid is the valid and rd_en the ready: a byte leaves when both are high.
  assign rd_valid  = (level_q != '0);
  assign fifo_full = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop       = rd_en && rd_valid;
  assign push      = rx_done && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d   = level_q;
    if (push && !pop) level_d = level_q + LVL_W'(1);
    if (pop && !push) level_d = level_q - LVL_W'(1);
    overrun_d = overrun_q;
    if (clr_overrun) overrun_d = 1'b0;
    // Set after clear so a drop in the same cycle as a clear is not lost.
    if (rx_done && !push) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage carries no reset; rd_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= r_data;
  end

  assign rd_data = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign level   = level_q;
  assign overrun = overrun_q;
  assign rx_irq  = (level_q >= LVL_W'(IRQ_LEVEL));
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: baud tick timing, FIFO push/pop table, overflow and reset corners.
module tb_uart_rx_ctrl;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV_WIDTH  = 16;
  localparam int IRQ_LEVEL  = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 enable;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 bd_tick;
  logic                 rx_done;
  logic [7:0]           r_data;
  logic                 rd_en;
  logic [7:0]           rd_data;
  logic                 rd_valid;
  logic                 fifo_full;
  logic [LVL_W-1:0]     level;
  logic                 overrun;
  logic                 clr_overrun;
  logic                 rx_irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic             rx_done;
    logic [7:0]       r_data;
    logic             rd_en;
    logic             clr;
    logic [LVL_W-1:0] e_level;
    logic             e_valid;
    logic [7:0]       e_data;
    logic             e_full;
    logic             e_ov;
    logic             e_irq;
  } vec_t;

  vec_t vecs[11];

  uart_rx_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_WIDTH  (DIV_WIDTH),
    .IRQ_LEVEL  (IRQ_LEVEL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .divisor     (divisor),
    .bd_tick     (bd_tick),
    .rx_done     (rx_done),
    .r_data      (r_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fifo_full   (fifo_full),
    .level       (level),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .rx_irq      (rx_irq)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_done = 1'b1;
    r_data  = b;
    step();
    rx_done = 1'b0;
    r_data  = 8'h00;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_valid"}, 32'(rd_valid), 0);
    chk({tag, "_full"}, 32'(fifo_full), 0);
    chk({tag, "_ov"}, 32'(overrun), 0);
    chk({tag, "_irq"}, 32'(rx_irq), 0);
    chk({tag, "_data"}, 32'(rd_data), 0);
    chk({tag, "_tick"}, 32'(bd_tick), 0);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; divisor = 16'd3;
    rx_done = 1'b0; r_data = 8'h00; rd_en = 1'b0; clr_overrun = 1'b0;

    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 4'd1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 4'd2, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h7E, 1'b0, 1'b0, 4'd3, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd3, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd2, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd1, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h11, 1'b1, 1'b0, 4'd1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h22, 1'b1, 1'b0, 4'd1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    #2;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Baud: divisor 3 -> tick on every 4th edge
    enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("tick_d3_%0d", k), 32'(bd_tick), 32'((k % 4) == 0));
    end
    enable = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("tick_off_%0d", k), 32'(bd_tick), 0);
    end
    enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("tick_reen_%0d", k), 32'(bd_tick), 32'((k % 4) == 0));
    end

    // Baud: divisor 10 reduced to 2 while count sits at 8
    enable = 1'b0;
    step();
    divisor = 16'd10;
    enable  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("tick_d10_%0d", k), 32'(bd_tick), 0);
    end
    divisor = 16'd2;
    for (int j = 1; j <= 7; j++) begin
      step();
      chk($sformatf("tick_d2_%0d", j), 32'(bd_tick), 32'((j % 3) == 1));
    end
    enable = 1'b0;
    step();

    // FIFO vector table
    for (int i = 0; i < 11; i++) begin
      rx_done = vecs[i].rx_done; r_data = vecs[i].r_data;
      rd_en = vecs[i].rd_en; clr_overrun = vecs[i].clr;
      step();
      rx_done = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
      chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].e_level));
      chk($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_data", i), 32'(rd_data), 32'(vecs[i].e_data));
      chk($sformatf("v%0d_full", i), 32'(fifo_full), 32'(vecs[i].e_full));
      chk($sformatf("v%0d_ov", i), 32'(overrun), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_irq", i), 32'(rx_irq), 32'(vecs[i].e_irq));
    end

    // Overflow: 9 pushes into 8 entries
    for (int b = 1; b <= 9; b++) begin
      push_byte(8'(b));
      if (b <= 8) exp_q.push_back(8'(b));
      chk($sformatf("ovf_level_%0d", b), 32'(level), (b > 8) ? 8 : b);
      chk($sformatf("ovf_full_%0d", b), 32'(fifo_full), 32'(b >= 8));
      chk($sformatf("ovf_ov_%0d", b), 32'(overrun), 32'(b == 9));
      chk($sformatf("ovf_irq_%0d", b), 32'(rx_irq), 32'(b >= 4));
    end
    chk("ovf_head", 32'(rd_data), 32'h01);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("clr_ov", 32'(overrun), 0);
    chk("clr_level", 32'(level), 8);

    // Full FIFO: push and pop together
    rx_done = 1'b1; r_data = 8'h55; rd_en = 1'b1;
    step();
    rx_done = 1'b0; rd_en = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h55);
    chk("fullpp_level", 32'(level), 8);
    chk("fullpp_ov", 32'(overrun), 0);
    chk("fullpp_head", 32'(rd_data), 32'h02);

    // Overflow coinciding with clear: set wins
    rx_done = 1'b1; r_data = 8'hAA; clr_overrun = 1'b1;
    step();
    rx_done = 1'b0; clr_overrun = 1'b0;
    chk("setclr_ov", 32'(overrun), 1);
    chk("setclr_level", 32'(level), 8);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("clr2_ov", 32'(overrun), 0);

    // Scoreboard drain
    while (exp_q.size() > 0) begin
      chk("drain_valid", 32'(rd_valid), 1);
      chk("drain_data", 32'(rd_data), 32'(exp_q[0]));
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      void'(exp_q.pop_front());
    end
    chk("drained_valid", 32'(rd_valid), 0);
    chk("drained_data", 32'(rd_data), 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("empty_pop_level", 32'(level), 0);
    chk("empty_pop_valid", 32'(rd_valid), 0);

    // IRQ threshold, then asynchronous reset mid-stream
    divisor = 16'd0;
    enable  = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      push_byte(8'(8'h40 + n));
      chk($sformatf("irq_%0d", n), 32'(rx_irq), 32'(n >= 4));
    end
    chk("pre_rst_ov", 32'(overrun), 1);
    chk("pre_rst_tick", 32'(bd_tick), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b0;
    step();
    chk("post_rst_level", 32'(level), 0);
    chk("post_rst_valid", 32'(rd_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
